// File: rtl/assoc_cache_lru.sv
// Fully-associative write-through cache with true-LRU replacement and optional write-allocate.
// Read hits ack one cycle after the request. Misses and writes wait on mem_ack, and busy blocks req/flush until then.
module assoc_cache_lru #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int CELL_CNT    = 4,
  parameter bit WRITE_ALLOC = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  ack,
  output logic                  hit,
  output logic                  busy,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack
);
  localparam int IW = $clog2(CELL_CNT);

  typedef enum logic [1:0] {IDLE, MEM_RD, MEM_WR} state_t;
  state_t state, state_nxt;

  logic [CELL_CNT-1:0]   valid;
  logic [ADDR_WIDTH-1:0] tag  [CELL_CNT];
  logic [DATA_WIDTH-1:0] data [CELL_CNT];
  logic [IW-1:0]         age  [CELL_CNT];

  logic          lk_hit, cap_hit, inv_found;
  logic [IW-1:0] lk_idx, cap_idx, inv_idx, old_idx, vic_idx;
  logic          fill_en, touch_en;
  logic [IW-1:0] fill_idx, touch_idx;
  logic [DATA_WIDTH-1:0] fill_data;

  assign busy = (state != IDLE);

  always_comb begin
    lk_hit    = 1'b0;
    lk_idx    = '0;
    inv_found = 1'b0;
    inv_idx   = '0;
    old_idx   = '0;
    for (int i = CELL_CNT - 1; i >= 0; i--) begin
      if (valid[i] && tag[i] == addr) begin
        lk_hit = 1'b1;
        lk_idx = IW'(i);
      end
      // Descending scan so the lowest-index invalid line wins
      if (!valid[i]) begin
        inv_found = 1'b1;
        inv_idx   = IW'(i);
      end
      if (age[i] == IW'(CELL_CNT - 1)) old_idx = IW'(i);
    end
    vic_idx = inv_found ? inv_idx : old_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fill_en   = 1'b0;
    fill_idx  = vic_idx;
    fill_data = mem_rdata;
    touch_en  = 1'b0;
    touch_idx = vic_idx;
    case (state)
      IDLE: begin
        if (!flush && req) begin
          if (we)          state_nxt = MEM_WR;
          else if (lk_hit) begin
            touch_en  = 1'b1;
            touch_idx = lk_idx;
          end
          else             state_nxt = MEM_RD;
        end
      end
      MEM_RD: begin
        if (mem_ack) begin
          state_nxt = IDLE;
          fill_en   = 1'b1;
          touch_en  = 1'b1;
        end
      end
      MEM_WR: begin
        if (mem_ack) begin
          state_nxt = IDLE;
          fill_data = mem_wdata;
          if (cap_hit) begin
            fill_en   = 1'b1;
            fill_idx  = cap_idx;
            touch_en  = 1'b1;
            touch_idx = cap_idx;
          end else if (WRITE_ALLOC) begin
            fill_en  = 1'b1;
            touch_en = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || (state == IDLE && flush)) begin
      valid <= '0;
      for (int i = 0; i < CELL_CNT; i++) age[i] <= IW'(i);
    end else begin
      if (fill_en) begin
        valid[fill_idx] <= 1'b1;
        tag[fill_idx]   <= mem_addr;
        data[fill_idx]  <= fill_data;
      end
      if (touch_en) begin
        for (int i = 0; i < CELL_CNT; i++) begin
          if (IW'(i) == touch_idx)        age[i] <= '0;
          else if (age[i] < age[touch_idx]) age[i] <= age[i] + IW'(1);
        end
      end
    end
  end

  // mem_addr/mem_wdata double as the captured request for the whole transaction
  always_ff @(posedge clk) begin
    if (rst) begin
      ack       <= 1'b0;
      hit       <= 1'b0;
      rdata     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cap_hit   <= 1'b0;
      cap_idx   <= '0;
    end else begin
      ack <= 1'b0;
      hit <= 1'b0;
      case (state)
        IDLE: begin
          if (!flush && req) begin
            cap_hit <= lk_hit;
            cap_idx <= lk_idx;
            if (we) begin
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              mem_addr  <= addr;
              mem_wdata <= wdata;
            end else if (lk_hit) begin
              ack   <= 1'b1;
              hit   <= 1'b1;
              rdata <= data[lk_idx];
            end else begin
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= addr;
            end
          end
        end
        MEM_RD: begin
          if (mem_ack) begin
            ack     <= 1'b1;
            rdata   <= mem_rdata;
            mem_req <= 1'b0;
          end
        end
        MEM_WR: begin
          if (mem_ack) begin
            ack     <= 1'b1;
            hit     <= cap_hit;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_assoc_cache_lru.sv
// Bench for assoc_cache_lru: memory responder, scoreboard of expected acks, second instance with WRITE_ALLOC=0.
module tb_assoc_cache_lru;
  logic       clk = 1'b0;
  logic       rst, req, we, flush, req_na;
  logic [7:0] addr, wdata;
  logic [7:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic       ack, hit, busy, mem_req, mem_we, mem_ack;
  logic [7:0] rdata_na, mem_addr_na, mem_wdata_na, mem_rdata_na;
  logic       ack_na, hit_na, busy_na, mem_req_na, mem_we_na, mem_ack_na;

  always #5 clk = ~clk;

  assoc_cache_lru u_dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .flush(flush),
    .rdata(rdata), .ack(ack), .hit(hit), .busy(busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  assoc_cache_lru #(.WRITE_ALLOC(1'b0)) u_dut_na (
    .clk(clk), .rst(rst), .req(req_na), .we(we), .addr(addr), .wdata(wdata), .flush(flush),
    .rdata(rdata_na), .ack(ack_na), .hit(hit_na), .busy(busy_na),
    .mem_req(mem_req_na), .mem_we(mem_we_na), .mem_addr(mem_addr_na), .mem_wdata(mem_wdata_na),
    .mem_rdata(mem_rdata_na), .mem_ack(mem_ack_na)
  );

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic       is_rd;
    logic       hit;
    logic [7:0] rdata;
  } exp_t;
  exp_t sb[$];

  logic [7:0] mem [256];
  int         mem_delay = 3;
  int         memreq_cyc = 0;
  int         wr_cnt = 0;
  logic [7:0] last_wr_addr = '0, last_wr_data = '0;

  // Memory responder: acks after mem_delay cycles of mem_req
  initial begin
    int cnt = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req) memreq_cyc++;
      if (mem_req && !mem_ack) begin
        cnt++;
        if (cnt >= mem_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = mem[mem_addr];
          if (mem_we) begin
            mem[mem_addr] = mem_wdata;
            last_wr_addr  = mem_addr;
            last_wr_data  = mem_wdata;
            wr_cnt++;
          end
          cnt = 0;
        end
      end else begin
        mem_ack = 1'b0;
        if (!mem_req) cnt = 0;
      end
    end
  end

  initial begin
    mem_ack_na   = 1'b0;
    mem_rdata_na = 8'h77;
    forever begin
      @(negedge clk);
      mem_ack_na = mem_req_na && !mem_ack_na;
    end
  end

  // Scoreboard monitor
  int ack_cnt = 0, run = 0, best_run = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (ack) begin
        ack_cnt++;
        run++;
        if (run > best_run) best_run = run;
        if (sb.size() == 0) check("unexpected_ack", ack_cnt, 0);
        else begin
          e = sb.pop_front();
          check("ack_hit", hit, e.hit);
          if (e.is_rd) check("ack_rdata", rdata, e.rdata);
        end
      end else run = 0;
    end
  end

  task automatic wait_idle(input string tag);
    bit done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) done = 1;
    end
    check({"done_", tag}, done, 1);
    sb.delete();
  endtask

  task automatic access(input logic w, input logic [7:0] a, input logic [7:0] d,
                        input logic exp_hit, input string tag);
    exp_t e;
    @(posedge clk); #1;
    memreq_cyc = 0;
    req = 1'b1; we = w; addr = a; wdata = d;
    e.is_rd = !w; e.hit = exp_hit; e.rdata = mem[a];
    sb.push_back(e);
    @(posedge clk); #1;
    req = 1'b0;
    wait_idle(tag);
  endtask

  task automatic do_flush();
    int a0;
    a0 = ack_cnt;
    @(posedge clk); #1;
    flush = 1'b1; req = 1'b1; we = 1'b0; addr = 8'h10;
    @(posedge clk); #1;
    flush = 1'b0; req = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("flush_no_ack", ack_cnt, a0);
  endtask

  task automatic na_access(input logic w, input logic [7:0] a, input logic [7:0] d,
                           output logic got_hit, output logic [7:0] got_rd, output logic ok);
    ok = 1'b0; got_hit = 1'b0; got_rd = '0;
    @(posedge clk); #1;
    req_na = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk); #1;
    req_na = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (ack_na) begin
        ok = 1'b1; got_hit = hit_na; got_rd = rdata_na;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int a0;
    logic h, ok;
    logic [7:0] rd;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[8'h10] = 8'hA5;
    rst = 1'b1; req = 1'b0; req_na = 1'b0; we = 1'b0; flush = 1'b0; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_ack", ack, 0);
    check("rst_hit", hit, 0);
    check("rst_busy", busy, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_rdata", rdata, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);

    access(1'b0, 8'h10, 8'h00, 1'b0, "rd10_miss");
    check("rd10_miss_memreq_cycles", memreq_cyc, 3);
    check("rd10_miss_rdata", rdata, 8'hA5);
    access(1'b0, 8'h10, 8'h00, 1'b1, "rd10_hit");
    check("rd10_hit_memreq_cycles", memreq_cyc, 0);

    access(1'b1, 8'h20, 8'h3C, 1'b0, "wr20");
    check("wr20_count", wr_cnt, 1);
    check("wr20_mem_addr", last_wr_addr, 8'h20);
    check("wr20_mem_wdata", last_wr_data, 8'h3C);
    access(1'b0, 8'h20, 8'h00, 1'b1, "rd20_hit");
    check("rd20_rdata", rdata, 8'h3C);
    access(1'b1, 8'h20, 8'h4D, 1'b1, "wr20_hit");
    access(1'b0, 8'h20, 8'h00, 1'b1, "rd20_hit2");
    check("rd20_rdata2", rdata, 8'h4D);

    do_flush();
    access(1'b0, 8'h10, 8'h00, 1'b0, "rd10_after_flush");

    // LRU: fill 1..4, touch 1, bring in 5 -> line holding 2 is the victim
    do_flush();
    for (int a = 1; a <= 4; a++) access(1'b0, 8'(a), 8'h00, 1'b0, "fill");
    access(1'b0, 8'h01, 8'h00, 1'b1, "touch01");
    access(1'b0, 8'h05, 8'h00, 1'b0, "rd05_miss");
    access(1'b0, 8'h02, 8'h00, 1'b0, "rd02_evicted");
    access(1'b0, 8'h01, 8'h00, 1'b1, "rd01_kept");
    access(1'b0, 8'h04, 8'h00, 1'b1, "rd04_kept");

    // Reset while a read miss is outstanding
    mem_delay = 1000;
    @(posedge clk); #1;
    req = 1'b1; we = 1'b0; addr = 8'h30;
    @(posedge clk); #1;
    req = 1'b0;
    check("abort_busy_before", busy, 1);
    check("abort_memreq_before", mem_req, 1);
    a0 = ack_cnt;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_memreq_after", mem_req, 0);
    check("abort_busy_after", busy, 0);
    repeat (5) @(posedge clk);
    #1 check("abort_no_ack", ack_cnt, a0);
    mem_delay = 3;
    access(1'b0, 8'h01, 8'h00, 1'b0, "rd01_after_rst");

    // Back-to-back hits
    access(1'b0, 8'h02, 8'h00, 1'b0, "fill02");
    access(1'b0, 8'h03, 8'h00, 1'b0, "fill03");
    best_run = 0;
    @(posedge clk); #1;
    req = 1'b1; we = 1'b0;
    for (int a = 1; a <= 3; a++) begin
      exp_t e;
      addr = 8'(a);
      e.is_rd = 1'b1; e.hit = 1'b1; e.rdata = mem[a];
      sb.push_back(e);
      @(posedge clk); #1;
    end
    req = 1'b0;
    wait_idle("b2b_hits");
    check("b2b_ack_run", best_run, 3);

    // WRITE_ALLOC=0 instance: write miss leaves the cache untouched
    na_access(1'b1, 8'h20, 8'h3C, h, rd, ok);
    check("na_wr_ack", ok, 1);
    check("na_wr_hit", h, 0);
    na_access(1'b0, 8'h20, 8'h00, h, rd, ok);
    check("na_rd_ack", ok, 1);
    check("na_rd_hit", h, 0);
    check("na_rd_rdata", rd, 8'h77);
    na_access(1'b0, 8'h20, 8'h00, h, rd, ok);
    check("na_rd2_hit", h, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
